// File: rtl/decoder_stage_pipe.sv
// Decode stage of a five-stage MIPS-style pipeline. It holds the 32-entry register file,
// decodes the instruction into control bits, reads operands and extends the immediate. It
// also detects load-use hazards and registers the ID/EX slot.
//
// Parameters:
//   DWIDTH - datapath / register width (32 or 64)
//   BYPASS - nonzero: a same-cycle writeback is forwarded to the read ports
//   HAZARD - nonzero: load-use stall detection enabled
//
// Ports:
//   dp_clk, dp_rst            clock, asynchronous active-low reset
//   dp_i_valid, dp_i_instr    incoming instruction and its valid flag
//   dp_i_flush                discard the instruction currently in decode
//   dp_i_wb_en/addr/data      register-file write port from writeback
//   dp_o_stall                combinational load-use stall request to upstream
//   dp_o_valid ... dp_o_jaddr registered ID/EX slot contents
module decoder_stage_pipe #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned BYPASS = 1,
    parameter int unsigned HAZARD = 1
) (
    input  logic              dp_clk,
    input  logic              dp_rst,
    input  logic              dp_i_valid,
    input  logic [31:0]       dp_i_instr,
    input  logic              dp_i_flush,
    input  logic              dp_i_wb_en,
    input  logic [4:0]        dp_i_wb_addr,
    input  logic [DWIDTH-1:0] dp_i_wb_data,
    output logic              dp_o_stall,
    output logic              dp_o_valid,
    output logic [7:0]        dp_o_ctrl,
    output logic [5:0]        dp_o_opcode,
    output logic [5:0]        dp_o_funct,
    output logic [4:0]        dp_o_addr_rs,
    output logic [4:0]        dp_o_addr_rt,
    output logic [4:0]        dp_o_addr_dst,
    output logic [DWIDTH-1:0] dp_o_data_rs,
    output logic [DWIDTH-1:0] dp_o_data_rt,
    output logic [DWIDTH-1:0] dp_o_imm,
    output logic [25:0]       dp_o_jaddr
);

    // Opcodes
    localparam logic [5:0] OpRType = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpBne   = 6'h05;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpSlti  = 6'h0A;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] FnJr    = 6'h08;

    // Control bit positions
    localparam int unsigned CRegWr    = 0;
    localparam int unsigned CMemWrite = 1;
    localparam int unsigned CMemToReg = 2;
    localparam int unsigned CAluSrc   = 3;
    localparam int unsigned CBranch   = 4;
    localparam int unsigned CJal      = 5;
    localparam int unsigned CJr       = 6;
    localparam int unsigned CJump     = 7;

    // ------------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------------
    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rs_idx;
    logic [4:0] rt_idx;
    logic [4:0] rd_idx;

    assign opcode = dp_i_instr[31:26];
    assign funct  = dp_i_instr[5:0];
    assign rs_idx = dp_i_instr[25:21];
    assign rt_idx = dp_i_instr[20:16];
    assign rd_idx = dp_i_instr[15:11];

    // ------------------------------------------------------------------------
    // Register file; entry 0 is never written, so it always reads zero
    // ------------------------------------------------------------------------
    logic [DWIDTH-1:0] rf_q [32];
    logic              rf_we;

    assign rf_we = dp_i_wb_en && (dp_i_wb_addr != 5'd0);

    always_ff @(posedge dp_clk or negedge dp_rst) begin
        if (!dp_rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[dp_i_wb_addr] <= dp_i_wb_data;
        end
    end

    logic [DWIDTH-1:0] rd_rs;
    logic [DWIDTH-1:0] rd_rt;

    always_comb begin
        rd_rs = '0;
        rd_rt = '0;
        if (rs_idx != 5'd0) begin
            if ((BYPASS != 0) && rf_we && (dp_i_wb_addr == rs_idx)) begin
                rd_rs = dp_i_wb_data;
            end else begin
                rd_rs = rf_q[rs_idx];
            end
        end
        if (rt_idx != 5'd0) begin
            if ((BYPASS != 0) && rf_we && (dp_i_wb_addr == rt_idx)) begin
                rd_rt = dp_i_wb_data;
            end else begin
                rd_rt = rf_q[rt_idx];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------------
    logic [7:0] dec_ctrl;
    logic [4:0] dec_dst;

    always_comb begin
        dec_ctrl = '0;
        dec_dst  = '0;
        case (opcode)
            OpRType: begin
                if (funct == FnJr) begin
                    dec_ctrl[CJr] = 1'b1;
                end else begin
                    dec_ctrl[CRegWr] = 1'b1;
                    dec_dst          = rd_idx;
                end
            end
            OpLw: begin
                dec_ctrl[CRegWr]    = 1'b1;
                dec_ctrl[CMemToReg] = 1'b1;
                dec_ctrl[CAluSrc]   = 1'b1;
                dec_dst             = rt_idx;
            end
            OpSw: begin
                dec_ctrl[CMemWrite] = 1'b1;
                dec_ctrl[CAluSrc]   = 1'b1;
            end
            OpBeq, OpBne: begin
                dec_ctrl[CBranch] = 1'b1;
            end
            OpAddi, OpSlti, OpAndi, OpOri: begin
                dec_ctrl[CRegWr]  = 1'b1;
                dec_ctrl[CAluSrc] = 1'b1;
                dec_dst           = rt_idx;
            end
            OpJ: begin
                dec_ctrl[CJump] = 1'b1;
            end
            OpJal: begin
                dec_ctrl[CJal]   = 1'b1;
                dec_ctrl[CJump]  = 1'b1;
                dec_ctrl[CRegWr] = 1'b1;
                dec_dst          = 5'd31;
            end
            default: begin
                // Unknown opcode: NOP
                dec_ctrl = '0;
                dec_dst  = '0;
            end
        endcase
    end

    // Logical immediates zero-extend; everything else sign-extends
    logic [DWIDTH-1:0] dec_imm;

    always_comb begin
        if ((opcode == OpAndi) || (opcode == OpOri)) begin
            dec_imm = {{(DWIDTH-16){1'b0}}, dp_i_instr[15:0]};
        end else begin
            dec_imm = {{(DWIDTH-16){dp_i_instr[15]}}, dp_i_instr[15:0]};
        end
    end

    // ------------------------------------------------------------------------
    // Load-use hazard
    // ------------------------------------------------------------------------
    logic rs_used;
    logic rt_used;
    logic hazard;

    assign rs_used = !((opcode == OpJ) || (opcode == OpJal));
    assign rt_used = (opcode == OpRType) || (opcode == OpSw) ||
                     (opcode == OpBeq)   || (opcode == OpBne);

    // The producing load sits in ID/EX; a bubble behind it clears the hazard next cycle
    assign hazard = dp_i_valid && dp_o_valid && dp_o_ctrl[CMemToReg] &&
                    (dp_o_addr_dst != 5'd0) &&
                    ((rs_used && (dp_o_addr_dst == rs_idx)) ||
                     (rt_used && (dp_o_addr_dst == rt_idx)));

    // Flush wins over stall so the squashed instruction is not held upstream
    assign dp_o_stall = (HAZARD != 0) && hazard && !dp_i_flush;

    // ------------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------------
    logic              issue;
    logic              valid_d;
    logic [7:0]        ctrl_d;
    logic [5:0]        opcode_d;
    logic [5:0]        funct_d;
    logic [4:0]        rs_d;
    logic [4:0]        rt_d;
    logic [4:0]        dst_d;
    logic [DWIDTH-1:0] data_rs_d;
    logic [DWIDTH-1:0] data_rt_d;
    logic [DWIDTH-1:0] imm_d;
    logic [25:0]       jaddr_d;

    assign issue = dp_i_valid && !dp_i_flush && !dp_o_stall;

    // Bubbles load all-zero so downstream never sees stale fields
    always_comb begin
        valid_d   = 1'b0;
        ctrl_d    = '0;
        opcode_d  = '0;
        funct_d   = '0;
        rs_d      = '0;
        rt_d      = '0;
        dst_d     = '0;
        data_rs_d = '0;
        data_rt_d = '0;
        imm_d     = '0;
        jaddr_d   = '0;
        if (issue) begin
            valid_d   = 1'b1;
            ctrl_d    = dec_ctrl;
            opcode_d  = opcode;
            funct_d   = funct;
            rs_d      = rs_idx;
            rt_d      = rt_idx;
            dst_d     = dec_dst;
            data_rs_d = rd_rs;
            data_rt_d = rd_rt;
            imm_d     = dec_imm;
            jaddr_d   = dp_i_instr[25:0];
        end
    end

    always_ff @(posedge dp_clk or negedge dp_rst) begin
        if (!dp_rst) begin
            dp_o_valid    <= 1'b0;
            dp_o_ctrl     <= '0;
            dp_o_opcode   <= '0;
            dp_o_funct    <= '0;
            dp_o_addr_rs  <= '0;
            dp_o_addr_rt  <= '0;
            dp_o_addr_dst <= '0;
            dp_o_data_rs  <= '0;
            dp_o_data_rt  <= '0;
            dp_o_imm      <= '0;
            dp_o_jaddr    <= '0;
        end else begin
            dp_o_valid    <= valid_d;
            dp_o_ctrl     <= ctrl_d;
            dp_o_opcode   <= opcode_d;
            dp_o_funct    <= funct_d;
            dp_o_addr_rs  <= rs_d;
            dp_o_addr_rt  <= rt_d;
            dp_o_addr_dst <= dst_d;
            dp_o_data_rs  <= data_rs_d;
            dp_o_data_rt  <= data_rt_d;
            dp_o_imm      <= imm_d;
            dp_o_jaddr    <= jaddr_d;
        end
    end

endmodule

// File: tb/tb_decoder_stage_pipe.sv
// Bench for decoder_stage_pipe: a default instance (bypass and hazard on) and an instance
// with both off, driven by the same stimulus.
module tb_decoder_stage_pipe;

    logic        dp_clk = 1'b0;
    logic        dp_rst;
    logic        i_valid;
    logic [31:0] i_instr;
    logic        i_flush;
    logic        i_wb_en;
    logic [4:0]  i_wb_addr;
    logic [31:0] i_wb_data;

    always #5 dp_clk = ~dp_clk;

    typedef struct packed {
        logic        valid;
        logic [7:0]  ctrl;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  dst;
        logic [31:0] drs;
        logic [31:0] drt;
        logic [31:0] imm;
        logic [25:0] jaddr;
    } outs_t;

    logic        m_stall, m_valid, a_stall, a_valid;
    logic [7:0]  m_ctrl, a_ctrl;
    logic [5:0]  m_opcode, m_funct, a_opcode, a_funct;
    logic [4:0]  m_rs, m_rt, m_dst, a_rs, a_rt, a_dst;
    logic [31:0] m_drs, m_drt, m_imm, a_drs, a_drt, a_imm;
    logic [25:0] m_jaddr, a_jaddr;
    outs_t       m_act, a_act;

    assign m_act = {m_valid, m_ctrl, m_opcode, m_funct, m_rs, m_rt, m_dst,
                    m_drs, m_drt, m_imm, m_jaddr};
    assign a_act = {a_valid, a_ctrl, a_opcode, a_funct, a_rs, a_rt, a_dst,
                    a_drs, a_drt, a_imm, a_jaddr};

    decoder_stage_pipe #(.DWIDTH(32), .BYPASS(1), .HAZARD(1)) u_main (
        .dp_clk        (dp_clk),
        .dp_rst        (dp_rst),
        .dp_i_valid    (i_valid),
        .dp_i_instr    (i_instr),
        .dp_i_flush    (i_flush),
        .dp_i_wb_en    (i_wb_en),
        .dp_i_wb_addr  (i_wb_addr),
        .dp_i_wb_data  (i_wb_data),
        .dp_o_stall    (m_stall),
        .dp_o_valid    (m_valid),
        .dp_o_ctrl     (m_ctrl),
        .dp_o_opcode   (m_opcode),
        .dp_o_funct    (m_funct),
        .dp_o_addr_rs  (m_rs),
        .dp_o_addr_rt  (m_rt),
        .dp_o_addr_dst (m_dst),
        .dp_o_data_rs  (m_drs),
        .dp_o_data_rt  (m_drt),
        .dp_o_imm      (m_imm),
        .dp_o_jaddr    (m_jaddr)
    );

    decoder_stage_pipe #(.DWIDTH(32), .BYPASS(0), .HAZARD(0)) u_alt (
        .dp_clk        (dp_clk),
        .dp_rst        (dp_rst),
        .dp_i_valid    (i_valid),
        .dp_i_instr    (i_instr),
        .dp_i_flush    (i_flush),
        .dp_i_wb_en    (i_wb_en),
        .dp_i_wb_addr  (i_wb_addr),
        .dp_i_wb_data  (i_wb_data),
        .dp_o_stall    (a_stall),
        .dp_o_valid    (a_valid),
        .dp_o_ctrl     (a_ctrl),
        .dp_o_opcode   (a_opcode),
        .dp_o_funct    (a_funct),
        .dp_o_addr_rs  (a_rs),
        .dp_o_addr_rt  (a_rt),
        .dp_o_addr_dst (a_dst),
        .dp_o_data_rs  (a_drs),
        .dp_o_data_rt  (a_drt),
        .dp_o_imm      (a_imm),
        .dp_o_jaddr    (a_jaddr)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: architectural register array plus decode rules
    // ------------------------------------------------------------------------
    logic [31:0] mregs [32];
    outs_t       exp_m, exp_a;

    function automatic logic [31:0] mread(input logic [4:0] idx, input bit bypass);
        if (idx == 5'd0) return 32'h0;
        if (bypass && i_wb_en && (i_wb_addr == idx)) return i_wb_data;
        return mregs[idx];
    endfunction

    function automatic outs_t mdecode(input logic [31:0] ins, input bit bypass);
        outs_t      o;
        logic [5:0] op;
        op      = ins[31:26];
        o       = '0;
        o.valid = 1'b1;
        o.opcode = op;
        o.funct = ins[5:0];
        o.rs    = ins[25:21];
        o.rt    = ins[20:16];
        o.jaddr = ins[25:0];
        o.drs   = mread(ins[25:21], bypass);
        o.drt   = mread(ins[20:16], bypass);
        if (op == 6'h0C || op == 6'h0D) o.imm = {16'h0, ins[15:0]};
        else                            o.imm = {{16{ins[15]}}, ins[15:0]};
        case (op)
            6'h00: if (ins[5:0] == 6'h08) o.ctrl = 8'h40;
                   else begin o.ctrl = 8'h01; o.dst = ins[15:11]; end
            6'h23: begin o.ctrl = 8'h0D; o.dst = ins[20:16]; end
            6'h2B: o.ctrl = 8'h0A;
            6'h04, 6'h05: o.ctrl = 8'h10;
            6'h08, 6'h0A, 6'h0C, 6'h0D: begin o.ctrl = 8'h09; o.dst = ins[20:16]; end
            6'h02: o.ctrl = 8'h80;
            6'h03: begin o.ctrl = 8'hA1; o.dst = 5'd31; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic bit mhazard(input outs_t cur, input bit hz);
        logic [5:0] op;
        bit rs_u, rt_u;
        op   = i_instr[31:26];
        rs_u = !(op == 6'h02 || op == 6'h03);
        rt_u = (op == 6'h00 || op == 6'h2B || op == 6'h04 || op == 6'h05);
        if (!hz || i_flush || !i_valid) return 1'b0;
        if (!(cur.valid && cur.ctrl[2] && cur.dst != 5'd0)) return 1'b0;
        return (rs_u && cur.dst == i_instr[25:21]) || (rt_u && cur.dst == i_instr[20:16]);
    endfunction

    // ------------------------------------------------------------------------
    // Directed vectors (registers start at zero after reset)
    // ------------------------------------------------------------------------
    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        flush;
        logic        wb_en;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        stall;
        logic        ovalid;
        logic [7:0]  ctrl;
        logic [4:0]  dst;
        logic [31:0] drs;
        logic [31:0] imm;
        logic        astall;
        logic [31:0] adrs;
    } vec_t;

    vec_t vecs [17];

    task automatic drive(input logic [31:0] ins, input logic v, input logic f,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        i_instr   = ins;
        i_valid   = v;
        i_flush   = f;
        i_wb_en   = we;
        i_wb_addr = wa;
        i_wb_data = wd;
    endtask

    bit          prev_stall;
    bit          sm, sa;
    outs_t       nm, na;

    initial begin
        vecs[0]  = '{32'h0,        0, 0, 1, 5, 32'h1234, 0, 0, 8'h00, 0,  32'h0,    32'h0,        0, 32'h0};
        vecs[1]  = '{32'h00A01820, 1, 0, 0, 0, 32'h0,    0, 1, 8'h01, 3,  32'h1234, 32'h00001820, 0, 32'h1234};
        vecs[2]  = '{32'h00E00820, 1, 0, 1, 7, 32'hDEAD, 0, 1, 8'h01, 1,  32'hDEAD, 32'h00000820, 0, 32'h0};
        vecs[3]  = '{32'h00001020, 1, 0, 1, 0, 32'hBEEF, 0, 1, 8'h01, 2,  32'h0,    32'h00001020, 0, 32'h0};
        vecs[4]  = '{32'h8C280004, 1, 0, 0, 0, 32'h0,    0, 1, 8'h0D, 8,  32'h0,    32'h00000004, 0, 32'h0};
        vecs[5]  = '{32'h01024820, 1, 0, 0, 0, 32'h0,    1, 0, 8'h00, 0,  32'h0,    32'h0,        0, 32'h0};
        vecs[6]  = '{32'h01024820, 1, 0, 0, 0, 32'h0,    0, 1, 8'h01, 9,  32'h0,    32'h00004820, 0, 32'h0};
        vecs[7]  = '{32'h3004FFFF, 1, 0, 0, 0, 32'h0,    0, 1, 8'h09, 4,  32'h0,    32'h0000FFFF, 0, 32'h0};
        vecs[8]  = '{32'h2004FFFF, 1, 0, 0, 0, 32'h0,    0, 1, 8'h09, 4,  32'h0,    32'hFFFFFFFF, 0, 32'h0};
        vecs[9]  = '{32'hFC000000, 1, 0, 0, 0, 32'h0,    0, 1, 8'h00, 0,  32'h0,    32'h0,        0, 32'h0};
        vecs[10] = '{32'h8C280004, 1, 0, 0, 0, 32'h0,    0, 1, 8'h0D, 8,  32'h0,    32'h00000004, 0, 32'h0};
        vecs[11] = '{32'h01024820, 1, 1, 0, 0, 32'h0,    0, 0, 8'h00, 0,  32'h0,    32'h0,        0, 32'h0};
        vecs[12] = '{32'h0,        0, 0, 0, 0, 32'h0,    0, 0, 8'h00, 0,  32'h0,    32'h0,        0, 32'h0};
        vecs[13] = '{32'h0C000010, 1, 0, 0, 0, 32'h0,    0, 1, 8'hA1, 31, 32'h0,    32'h00000010, 0, 32'h0};
        vecs[14] = '{32'h03E00008, 1, 0, 0, 0, 32'h0,    0, 1, 8'h40, 0,  32'h0,    32'h00000008, 0, 32'h0};
        vecs[15] = '{32'hACA50000, 1, 0, 0, 0, 32'h0,    0, 1, 8'h0A, 0,  32'h1234, 32'h0,        0, 32'h1234};
        vecs[16] = '{32'h10A7FFFE, 1, 0, 0, 0, 32'h0,    0, 1, 8'h10, 0,  32'h1234, 32'hFFFFFFFE, 0, 32'h1234};

        dp_rst = 1'b0;
        drive(32'h0, 0, 0, 0, 0, 32'h0);
        #2;
        chk("reset_main_outs", m_act, '0);
        chk("reset_alt_outs", a_act, '0);
        chk("reset_stall", {159'b0, m_stall}, '0);
        @(posedge dp_clk);
        #1;
        dp_rst = 1'b1;

        // Directed table
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].instr, vecs[i].valid, vecs[i].flush,
                  vecs[i].wb_en, vecs[i].wa, vecs[i].wd);
            #1;
            chk($sformatf("vec%0d_stall", i), {159'b0, m_stall}, {159'b0, vecs[i].stall});
            chk($sformatf("vec%0d_alt_stall", i), {159'b0, a_stall}, {159'b0, vecs[i].astall});
            @(posedge dp_clk);
            #1;
            chk($sformatf("vec%0d_outs", i), {81'b0, m_valid, m_ctrl, m_dst, m_drs, m_imm},
                {81'b0, vecs[i].ovalid, vecs[i].ctrl, vecs[i].dst, vecs[i].drs, vecs[i].imm});
            chk($sformatf("vec%0d_alt_rs", i), {128'b0, a_drs}, {128'b0, vecs[i].adrs});
        end

        // Asynchronous reset in the middle of a load-use stall
        drive(32'h8C280004, 1, 0, 0, 0, 32'h0);
        @(posedge dp_clk);
        #1;
        drive(32'h01024820, 1, 0, 0, 0, 32'h0);
        #1;
        chk("pre_reset_stall", {159'b0, m_stall}, {159'b0, 1'b1});
        dp_rst = 1'b0;
        #1;
        chk("midcycle_reset_main", m_act, '0);
        chk("midcycle_reset_alt", a_act, '0);
        chk("midcycle_reset_stall", {159'b0, m_stall}, '0);
        #1;
        dp_rst = 1'b1;
        @(posedge dp_clk);
        #1;
        chk("post_reset_issue", {145'b0, m_valid, m_ctrl, m_dst, m_rs},
            {145'b0, 1'b1, 8'h01, 5'd9, 5'd8});
        drive(32'h00A00820, 1, 0, 0, 0, 32'h0);
        @(posedge dp_clk);
        #1;
        chk("post_reset_r5", {128'b0, m_drs}, '0);
        drive(32'h00E00820, 1, 0, 0, 0, 32'h0);
        @(posedge dp_clk);
        #1;
        chk("post_reset_r7", {128'b0, m_drs}, '0);

        // Randomized run against the reference model
        dp_rst = 1'b0;
        #1;
        dp_rst = 1'b1;
        for (int r = 0; r < 32; r++) mregs[r] = 32'h0;
        exp_m      = '0;
        exp_a      = '0;
        prev_stall = 1'b0;
        for (int c = 0; c < 500; c++) begin
            logic [5:0] ops [13];
            logic [5:0] op;
            ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0A, 6'h0C, 6'h0D,
                    6'h02, 6'h03, 6'h3F, 6'h23};
            if (!prev_stall) begin
                op = ops[$urandom_range(0, 12)];
                i_instr = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                           16'($urandom)};
                if ($urandom_range(0, 3) == 0) i_instr[5:0] = 6'h08;
                i_valid = ($urandom_range(0, 99) < 85);
            end
            i_flush   = ($urandom_range(0, 99) < 10);
            i_wb_en   = $urandom_range(0, 1) == 1;
            i_wb_addr = 5'($urandom_range(0, 7));
            i_wb_data = $urandom;
            #1;
            sm = mhazard(exp_m, 1'b1);
            sa = mhazard(exp_a, 1'b0);
            chk($sformatf("rnd%0d_stall", c), {159'b0, m_stall}, {159'b0, sm});
            chk($sformatf("rnd%0d_alt_stall", c), {159'b0, a_stall}, {159'b0, sa});
            nm = (i_valid && !i_flush && !sm) ? mdecode(i_instr, 1'b1) : '0;
            na = (i_valid && !i_flush && !sa) ? mdecode(i_instr, 1'b0) : '0;
            @(posedge dp_clk);
            if (i_wb_en && i_wb_addr != 5'd0) mregs[i_wb_addr] = i_wb_data;
            exp_m = nm;
            exp_a = na;
            #1;
            chk($sformatf("rnd%0d_outs", c), m_act, exp_m);
            chk($sformatf("rnd%0d_alt_outs", c), a_act, exp_a);
            prev_stall = sm;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
